// File: rtl/multi_lane_neuron_core.sv
// NUM_LANES parallel neurons: signed MAC over a broadcast input stream, saturating
// rescale, then a run-time selected activation (identity / ReLU / PWL sigmoid).
module multi_lane_neuron_core #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int NUM_LANES  = 4,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                            clk,
    input  logic                            reset_b,
    input  logic                            start,
    input  logic [1:0]                      act_mode,
    input  logic                            term_valid,
    input  logic                            term_last,
    input  logic [DATA_WIDTH-1:0]           input_value,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] weight_value,
    output logic                            term_ready,
    output logic                            busy,
    output logic                            result_valid,
    output logic [NUM_LANES*DATA_WIDTH-1:0] result,
    output logic [NUM_LANES-1:0]            overflow
);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACTIVATE, S_DONE} state_e;

    localparam logic signed [DATA_WIDTH-1:0] MINV = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MAXV = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    // Sigmoid breakpoints and offsets expressed in the active fixed-point format
    localparam logic signed [DATA_WIDTH-1:0] ONE  = DATA_WIDTH'(2 ** FRAC_BITS);
    localparam logic signed [DATA_WIDTH-1:0] BRK5 = DATA_WIDTH'(5 * (2 ** FRAC_BITS));
    localparam logic signed [DATA_WIDTH-1:0] BRK2 = DATA_WIDTH'(19 * (2 ** (FRAC_BITS - 3)));
    localparam logic signed [DATA_WIDTH-1:0] OFS2 = DATA_WIDTH'(27 * (2 ** (FRAC_BITS - 5)));
    localparam logic signed [DATA_WIDTH-1:0] OFS1 = DATA_WIDTH'(5 * (2 ** (FRAC_BITS - 3)));
    localparam logic signed [DATA_WIDTH-1:0] OFS0 = DATA_WIDTH'(2 ** (FRAC_BITS - 1));

    state_e                          state_q, state_d;
    logic [1:0]                      mode_q, mode_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] result_q, result_d, res_lane;
    logic [NUM_LANES-1:0]            overflow_q, overflow_d, ov_lane;
    logic                            start_ok, term_acc;

    function automatic logic signed [DATA_WIDTH-1:0] sigmoid(input logic signed [DATA_WIDTH-1:0] x);
        logic signed [DATA_WIDTH-1:0] a, f;
        if (x == MINV)      a = MAXV;
        else if (x < 0)     a = -x;
        else                a = x;
        if (a >= BRK5)      f = ONE;
        else if (a >= BRK2) f = (a >>> 5) + OFS2;
        else if (a >= ONE)  f = (a >>> 3) + OFS1;
        else                f = (a >>> 2) + OFS0;
        return x[DATA_WIDTH-1] ? ONE - f : f;
    endfunction

    assign start_ok = (state_q == S_IDLE) && start;
    assign term_acc = (state_q == S_ACCUM) && term_valid;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_ACCUM;
            S_ACCUM:    if (term_valid && term_last) state_d = S_ACTIVATE;
            S_ACTIVATE: state_d = S_DONE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        term_ready   = (state_q == S_ACCUM);
        busy         = (state_q != S_IDLE);
        result_valid = (state_q == S_DONE);
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic signed [ACC_WIDTH-1:0]    acc_q, acc_d, shifted;
        logic signed [2*DATA_WIDTH-1:0] prod;
        logic signed [DATA_WIDTH-1:0]   x, act;
        logic                           sat;

        always_comb begin
            prod  = $signed(input_value) * $signed(weight_value[l*DATA_WIDTH +: DATA_WIDTH]);
            acc_d = acc_q;
            if (start_ok)      acc_d = '0;
            else if (term_acc) acc_d = acc_q + ACC_WIDTH'(prod);
            // Value fits when every bit above the result's sign bit matches it
            shifted = acc_q >>> FRAC_BITS;
            sat = !((&shifted[ACC_WIDTH-1:DATA_WIDTH-1]) || !(|shifted[ACC_WIDTH-1:DATA_WIDTH-1]));
            if (!sat)                    x = shifted[DATA_WIDTH-1:0];
            else if (shifted[ACC_WIDTH-1]) x = MINV;
            else                         x = MAXV;
            case (mode_q)
                2'b01:   act = x[DATA_WIDTH-1] ? '0 : x;
                2'b10:   act = sigmoid(x);
                default: act = x;
            endcase
        end

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) acc_q <= '0;
            else          acc_q <= acc_d;
        end

        assign res_lane[l*DATA_WIDTH +: DATA_WIDTH] = act;
        assign ov_lane[l] = sat;
    end

    always_comb begin
        mode_d     = mode_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        if (start_ok) mode_d = act_mode;
        if (state_q == S_ACTIVATE) begin
            result_d   = res_lane;
            overflow_d = ov_lane;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            mode_q     <= '0;
            result_q   <= '0;
            overflow_q <= '0;
        end else begin
            mode_q     <= mode_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: doc/multi_lane_neuron_core.md
# multi_lane_neuron_core

Parametrised successor to the single-lane calculator/sigmoid core. It computes NUM_LANES neurons in parallel from one broadcast input stream and per-lane weight streams, with full-precision signed multiply-accumulate and saturating rescale. A run-time selectable activation (identity, ReLU or piecewise-linear sigmoid) is applied, and the results are held in output registers until the next run. It sits between the layer sequencer, which supplies terms, and the layer result buffer.

## Interface
Parameters:
- DATA_WIDTH, 16: signed fixed-point width of input, weight and result.
- FRAC_BITS, 8: fractional bits; default format is Q8.8, so 1.0 = 0x0100.
- NUM_LANES, 4: number of parallel neurons.
- ACC_WIDTH, 40: signed accumulator width; must be ≥ 2*DATA_WIDTH.

Ports:
- clk, input, 1: system clock; single clock domain.
- reset_b, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse that begins a run; honoured only in IDLE.
- act_mode, input, 2: 00 identity, 01 ReLU, 10 sigmoid, 11 identity. Sampled on the start cycle.
- term_valid, input, 1: a term (input, weights) is presented.
- term_last, input, 1: qualifies the final term of the run; meaningful only with term_valid.
- input_value, input, DATA_WIDTH: layer input, broadcast to all lanes.
- weight_value, input, NUM_LANES*DATA_WIDTH: packed weights; lane i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- term_ready, output, 1: high in ACCUM; a term is accepted when term_valid && term_ready.
- busy, output, 1: high in any state other than IDLE.
- result_valid, output, 1: one-cycle pulse when results update.
- result, output, NUM_LANES*DATA_WIDTH: packed activated results, registered and held.
- overflow, output, NUM_LANES: per-lane flag, set if that lane's rescale saturated. Registered and held with result.

## Operation
State machine:
- IDLE → ACCUM on start. Every accumulator is cleared and act_mode is latched.
- ACCUM: each accepted term adds sign-extended (input_value*weight_lane) to each lane's accumulator. The product is 2*DATA_WIDTH signed, with no truncation. An accepted term with term_last moves the state to ACTIVATE.
- ACTIVATE: for each lane, acc >>> FRAC_BITS (arithmetic shift), then saturate to the signed DATA_WIDTH range, giving x. The overflow bit is set if saturation occurred. The activation is applied to x and result and overflow are registered. The state moves to DONE.
- DONE: result_valid=1 for this cycle, then the state returns to IDLE.

Activations (Q8.8 values shown; the breakpoints scale with FRAC_BITS):
- Identity: result = x.
- ReLU: result = x if x ≥ 0, else 0.
- Sigmoid: computed as f(|x|), with |x| saturated to the maximum positive value, then y = f for x ≥ 0 and y = 1.0 − f for x < 0. The segments of f(a) are:
  - a ≥ 5.0: f = 1.0.
  - 2.375 ≤ a < 5.0: f = a/32 + 0.84375.
  - 1.0 ≤ a < 2.375: f = a/8 + 0.625.
  - a < 1.0: f = a/4 + 0.5.
  - Divisions are arithmetic right shifts, truncating.

Boundary conditions:
- start while busy: ignored; no restart and no clearing.
- term_valid outside ACCUM: ignored. term_last without term_valid: ignored.
- Accumulator overflow beyond ACC_WIDTH is not detected; the sequencer guarantees the term count fits.
- result and overflow change only on the ACTIVATE→DONE edge. They hold their values through IDLE and through the next ACCUM.
- Asserting reset_b low at any time forces IDLE immediately, with no clock needed. The run is abandoned and no result_valid is produced.

## Timing
- Reset values: term_ready=0, busy=0, result_valid=0, result=0, overflow=0. The accumulators are also reset to 0.
- start sampled at edge N: busy and term_ready are high from N+1, and the first term can be accepted at edge N+1.
- Throughput: one term per cycle with no bubbles.
- term_last accepted at edge M:
  - ACTIVATE during cycle M+1.
  - result, overflow and result_valid change at edge M+2.
  - IDLE and busy=0 at edge M+3.
  - A new start is accepted at edge M+3 at the earliest.
- Minimum run, from the start edge to the result_valid edge: 3 cycles, for a single term.

## Test plan
- Identity, one term: input=0x0200 with lane weights {0x0180, 0xFF00, 0x0000, 0x0100} and term_last → result lanes {0x0300, 0xFE00, 0x0000, 0x0200}, overflow=0, result_valid exactly 2 cycles after the term.
- ReLU over a 3-term run: input stream 0x0100, 0x0100, 0x0100 with lane0 weights 0x0080, 0xFF00, 0xFF00 → lane0 = 0x0000 (the pre-activation value is −1.5). The same run in identity mode gives 0xFE80.
- Sigmoid values:
  - x = 0 → 0x0080.
  - x = 1.0 (0x0100) → 0x00C0.
  - x = −1.0 → 0x0040.
  - x = 6.0 → 0x0100.
  - x = −6.0 → 0x0000.
- Saturation: 4 terms of 0x7FFF*0x7FFF on lane0 and 4 terms of 0x7FFF*0x8000 on lane1, identity mode → lane0=0x7FFF, lane1=0x8000, overflow=0b0011.
- Protocol: a start pulse in ACCUM is ignored and the accumulation continues. A term_valid in IDLE leaves the accumulators at 0. A gapped term_valid gives the same result as a back-to-back stream.
- Reset in mid-run: assert reset_b during ACCUM → all outputs read 0 with no clock edge. The next run's result is correct and unaffected by the abandoned run.
